pc_sequencer: RTL and testbench

Next-PC controller for the single-cycle core: drives `pcNext` into the `pc` register every cycle and sequences boot, normal fetch, redirects, stall and debug halt. Registered state lives here and the `pc` register stays a plain flop. All redirect sources (branch, jump, optional trap) are arbitrated in this block. It also keeps a retired-instruction counter and an exception PC.

---
 rtl/pc_pkg.sv | 26 ++
 rtl/pc_redirect_mux.sv | 37 +++
 rtl/pc_sequencer.sv | 105 ++++++++++
 tb/tb_pc_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the next-PC sequencer.
// PC_TRAP_EN selects misaligned-target trapping instead of silent target alignment.
package pc_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP              = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

`ifdef PC_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } pc_state_e;

  function automatic logic misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_redirect_mux.sv
// RUN-state next-PC select: trap > jump > branch > stall > pc+4, plus misaligned-target detection.
// Purely combinational; trap path only exists when PC_TRAP_EN is defined.
module pc_redirect_mux
  import pc_pkg::*;
#(
  parameter logic [XLEN-1:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            jump_vld_i,
  input  logic [XLEN-1:0] jump_target_i,
  input  logic            stall_i,
  output logic [XLEN-1:0] pc_next_o,
  output logic            trap_o
);

  logic            redirect;
  logic [XLEN-1:0] target;

  assign redirect = jump_vld_i | branch_taken_i;
  assign target   = jump_vld_i ? jump_target_i : branch_target_i;
  // With trapping disabled this folds to 0 and the target is simply word-aligned.
  assign trap_o   = TRAP_EN && redirect && misaligned(target);

  always_comb begin
    pc_next_o = pc_i + PC_STEP;
    if (trap_o) begin
      pc_next_o = TRAP_VECTOR;
    end else if (redirect) begin
      pc_next_o = {target[XLEN-1:2], 2'b00};
    end else if (stall_i) begin
      pc_next_o = pc_i;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: BOOT/RUN/HALT sequencing, redirect arbitration, instret and epc.
// PC_TRAP_EN enables misaligned-fetch traps; otherwise trapTaken and epc stay 0.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR,
  parameter int              BOOT_CYCLES  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic            branchTaken,
  input  logic [XLEN-1:0] branchTarget,
  input  logic            jumpValid,
  input  logic [XLEN-1:0] jumpTarget,
  input  logic            stall,
  input  logic            haltReq,
  input  logic            resumeReq,
  output logic [XLEN-1:0] pcNext,
  output logic            fetchValid,
  output logic            halted,
  output logic [XLEN-1:0] instret,
  output logic [XLEN-1:0] epc,
  output logic            trapTaken
);

  localparam int              CNT_W     = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

  pc_state_e        state_q;
  logic [CNT_W-1:0] boot_cnt_q;
  logic [XLEN-1:0]  instret_q, instret_d;
  logic [XLEN-1:0]  epc_q;
  logic [XLEN-1:0]  run_pc_next;
  logic             run_trap;

  pc_redirect_mux #(
    .TRAP_VECTOR(TRAP_VECTOR)
  ) u_redirect (
    .pc_i           (pc),
    .branch_taken_i (branchTaken),
    .branch_target_i(branchTarget),
    .jump_vld_i     (jumpValid),
    .jump_target_i  (jumpTarget),
    .stall_i        (stall),
    .pc_next_o      (run_pc_next),
    .trap_o         (run_trap)
  );

  assign instret_d = instret_q + 32'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= '0;
      instret_q  <= '0;
      epc_q      <= '0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          if (boot_cnt_q == BOOT_LAST) begin
            state_q    <= ST_RUN;
            boot_cnt_q <= '0;
          end else begin
            boot_cnt_q <= boot_cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (run_trap) epc_q <= pc;
          if (!stall && !run_trap) instret_q <= instret_d;
          // The halting cycle's redirect is still honoured by the combinational path.
          if (haltReq) state_q <= ST_HALT;
        end
        ST_HALT: begin
          if (resumeReq) state_q <= ST_RUN;
        end
        default: state_q <= ST_BOOT;
      endcase
    end
  end

  always_comb begin
    pcNext     = RESET_VECTOR;
    fetchValid = 1'b0;
    halted     = 1'b0;
    trapTaken  = 1'b0;
    case (state_q)
      ST_RUN: begin
        pcNext     = run_pc_next;
        fetchValid = 1'b1;
        trapTaken  = run_trap;
      end
      ST_HALT: begin
        pcNext = pc;
        halted = 1'b1;
      end
      default: ;
    endcase
  end

  assign instret = instret_q;
  assign epc     = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a behavioural model; honours PC_TRAP_EN.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;
  localparam int          BC = 4;
`ifdef PC_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = 32'h0;
  logic        branchTaken = 1'b0, jumpValid = 1'b0, stall = 1'b0;
  logic        haltReq = 1'b0, resumeReq = 1'b0;
  logic [31:0] branchTarget = 32'h0, jumpTarget = 32'h0;
  logic [31:0] pcNext, instret, epc;
  logic        fetchValid, halted, trapTaken;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV), .BOOT_CYCLES(BC)) dut (
    .clk(clk), .reset(reset), .pc(pc),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .jumpValid(jumpValid), .jumpTarget(jumpTarget),
    .stall(stall), .haltReq(haltReq), .resumeReq(resumeReq),
    .pcNext(pcNext), .fetchValid(fetchValid), .halted(halted),
    .instret(instret), .epc(epc), .trapTaken(trapTaken)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model: boot cycles still to go, halted flag, counters.
  int          m_boot_left;
  bit          m_halted;
  logic [31:0] m_instret, m_epc;

  task automatic model_reset();
    m_boot_left = BC;
    m_halted    = 1'b0;
    m_instret   = 32'h0;
    m_epc       = 32'h0;
  endtask

  task automatic model_out(output logic [31:0] npc, output logic fv, output logic hl, output logic tt);
    logic [31:0] tgt;
    npc = RV; fv = 1'b0; hl = 1'b0; tt = 1'b0;
    if (reset || m_boot_left > 0) begin
      npc = RV;
    end else if (m_halted) begin
      npc = pc; hl = 1'b1;
    end else begin
      fv = 1'b1;
      if (jumpValid || branchTaken) begin
        tgt = jumpValid ? jumpTarget : branchTarget;
        if (TRAP_ON && (tgt % 4 != 0)) begin
          npc = TV; tt = 1'b1;
        end else begin
          npc = tgt - (tgt % 4);
        end
      end else if (stall) begin
        npc = pc;
      end else begin
        npc = pc + 32'd4;
      end
    end
  endtask

  task automatic model_advance();
    logic [31:0] npc;
    logic fv, hl, tt;
    model_out(npc, fv, hl, tt);
    if (reset) begin
      model_reset();
    end else if (m_boot_left > 0) begin
      m_boot_left = m_boot_left - 1;
    end else if (m_halted) begin
      if (resumeReq) m_halted = 1'b0;
    end else begin
      if (tt) m_epc = pc;
      if (!stall && !tt) m_instret = m_instret + 32'd1;
      if (haltReq) m_halted = 1'b1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e_npc;
    logic e_fv, e_hl, e_tt;
    if (chk_en) begin
      model_out(e_npc, e_fv, e_hl, e_tt);
      check("cyc_pcNext",     pcNext,            e_npc);
      check("cyc_fetchValid", 32'(fetchValid),   32'(e_fv));
      check("cyc_halted",     32'(halted),       32'(e_hl));
      check("cyc_trapTaken",  32'(trapTaken),    32'(e_tt));
      check("cyc_instret",    instret,           m_instret);
      check("cyc_epc",        epc,               m_epc);
    end
  end

  // One clock: model sees pre-edge inputs, pc register captures the expected pcNext.
  task automatic tick();
    logic [31:0] npc;
    logic fv, hl, tt;
    model_out(npc, fv, hl, tt);
    @(posedge clk);
    #1;
    model_advance();
    pc = npc;
  endtask

  task automatic idle();
    branchTaken = 1'b0; jumpValid = 1'b0; stall = 1'b0;
    haltReq = 1'b0; resumeReq = 1'b0;
  endtask

  initial begin
    logic [31:0] t;
    model_reset();
    chk_en = 1'b1;
    tick(); tick();
    check("rst_pcNext", pcNext, 32'h0);
    check("rst_fetchValid", 32'(fetchValid), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_trapTaken", 32'(trapTaken), 32'h0);
    check("rst_instret", instret, 32'h0);
    check("rst_epc", epc, 32'h0);
    reset = 1'b0;

    for (int c = 0; c < BC; c++) begin
      #1;
      check("boot_fetchValid", 32'(fetchValid), 32'h0);
      check("boot_pcNext", pcNext, 32'h0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      #1;
      check("seq_fetchValid", 32'(fetchValid), 32'h1);
      check("seq_pcNext", pcNext, 32'(4 * (k + 1)));
      tick();
    end
    check("seq_instret", instret, 32'd4);

    pc = 32'h40; branchTaken = 1'b1; branchTarget = 32'h80; jumpValid = 1'b1; jumpTarget = 32'hC0;
    #1 check("prio_jump", pcNext, 32'hC0);
    tick(); idle();
    pc = 32'h40; stall = 1'b1;
    #1 check("stall_pcNext", pcNext, 32'h40);
    tick();
    check("stall_instret", instret, 32'd5);
    idle();
    pc = 32'hFFFF_FFFC;
    #1 check("wrap_pcNext", pcNext, 32'h0);
    tick();
    check("wrap_instret", instret, 32'd6);

    branchTaken = 1'b1; branchTarget = 32'h200; haltReq = 1'b1;
    #1 check("haltreq_pcNext", pcNext, 32'h200);
    check("haltreq_halted", 32'(halted), 32'h0);
    tick(); idle();
    for (int h = 0; h < 3; h++) begin
      if (h == 1) begin branchTaken = 1'b1; branchTarget = 32'h300; stall = 1'b1; end
      #1;
      check("halt_halted", 32'(halted), 32'h1);
      check("halt_pcNext", pcNext, 32'h200);
      check("halt_fetchValid", 32'(fetchValid), 32'h0);
      tick(); idle();
    end
    haltReq = 1'b1; resumeReq = 1'b1;
    #1 check("resume_pcNext", pcNext, 32'h200);
    tick(); idle();
    #1;
    check("resumed_halted", 32'(halted), 32'h0);
    check("resumed_pcNext", pcNext, 32'h204);
    check("resumed_instret", instret, 32'd7);
    tick();

    pc = 32'h20; jumpValid = 1'b1; jumpTarget = 32'h102;
    #1 check("trap_pcNext", pcNext, 32'h100);
    check("trap_taken", 32'(trapTaken), 32'(TRAP_ON));
    tick(); idle();
    check("trap_epc", epc, TRAP_ON ? 32'h20 : 32'h0);
    check("trap_instret", instret, TRAP_ON ? 32'd8 : 32'd9);

    for (int i = 0; i < 3000; i++) begin
      branchTaken = ($urandom_range(4) == 0);
      jumpValid   = ($urandom_range(6) == 0);
      stall       = ($urandom_range(4) == 0);
      haltReq     = ($urandom_range(24) == 0);
      resumeReq   = ($urandom_range(3) == 0);
      t = $urandom; if ($urandom_range(3) != 0) t[1:0] = 2'b00;
      branchTarget = t;
      t = $urandom; if ($urandom_range(3) != 0) t[1:0] = 2'b00;
      jumpTarget = t;
      if ($urandom_range(49) == 0) begin
        t = $urandom; t[1:0] = 2'b00;
        pc = ($urandom_range(1) == 0) ? 32'hFFFF_FFFC : t;
      end
      tick();
    end

    idle(); resumeReq = 1'b1;
    for (int w = 0; w < 10 && (m_boot_left > 0 || m_halted); w++) tick();
    idle();
    tick(); tick();
    reset = 1'b1;
    #1;
    check("arst_pcNext", pcNext, RV);
    check("arst_fetchValid", 32'(fetchValid), 32'h0);
    check("arst_halted", 32'(halted), 32'h0);
    check("arst_trapTaken", 32'(trapTaken), 32'h0);
    check("arst_instret", instret, 32'h0);
    check("arst_epc", epc, 32'h0);
    model_reset();
    tick(); tick();
    reset = 1'b0;
    for (int c = 0; c < BC + 3; c++) tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
